// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default datapath width and the divider state encoding.
// The default width is common to the combinational arithmetic unit and the divider.
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// and keep the difference when it does not go negative.
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    assign shifted          = {rem_in[WIDTH-1:0], bit_in};
    assign {borrow, diff}   = {1'b0, shifted} - {2'b00, divisor};

    // A set top bit would mean the shifted value already exceeds any divisor,
    // so the trial can never be negative in that case.
    assign q_bit   = rem_in[WIDTH] | ~borrow;
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, MSB first,
// with registered quotient/remainder/divide-by-zero and a one-cycle done pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; operands sampled here only
//   ST_RUN  | one restoring step per cycle, counter WIDTH-1 down to 0
//   ST_DONE | single output cycle with done high, then back to idle
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    div_state_e        state;
    div_state_e        state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  dvd_q;
    logic [WIDTH-1:0]  dvs_q;
    logic [WIDTH:0]    rem_q;
    logic [WIDTH:0]    rem_nxt;
    logic              q_bit;
    logic              accept;
    logic              zero_div;
    logic              step_en;
    logic              last_step;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_div  = 1'b0;
        step_en   = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        zero_div  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                step_en = 1'b1;
                if (cnt == '0) begin
                    last_step = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The dividend register doubles as the quotient accumulator: each step shifts
    // out the consumed dividend bit and shifts in the new quotient bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_nxt == ST_DONE);

            if (accept) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt   <= CNT_LAST;
            end else if (step_en) begin
                dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                rem_q <= rem_nxt;
                cnt   <= cnt - 1'b1;
            end

            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else if (last_step) begin
                quotient    <= {dvd_q[WIDTH-2:0], q_bit};
                remainder   <= rem_nxt[WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=8 and WIDTH=16: a cycle-level arithmetic model
// checked every cycle, plus directed cases with literal expected results.
module tb_seq_divider;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        st8 = 1'b0;
    logic [7:0]  dd8 = '0, dv8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  q8, r8;

    logic        st16 = 1'b0;
    logic [15:0] dd16 = '0, dv16 = '0;
    logic        busy16, done16, dz16;
    logic [15:0] q16, r16;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state per unit (0: WIDTH=8, 1: WIDTH=16)
    int m_done [2] = '{-10, -10};
    int m_acc  [2] = '{-10, -10};
    int m_nacc [2] = '{0, 0};
    int m_q    [2] = '{0, 0};
    int m_r    [2] = '{0, 0};
    int m_z    [2] = '{0, 0};
    int p_q    [2] = '{0, 0};
    int p_r    [2] = '{0, 0};
    int p_z    [2] = '{0, 0};

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .dividend(dd8), .divisor(dv8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    seq_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .dividend(dd16), .divisor(dv16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int u = 0; u < 2; u++) begin
            m_done[u] = -10;
            m_acc[u]  = -10;
            m_q[u]    = 0;
            m_r[u]    = 0;
            m_z[u]    = 0;
        end
    endtask

    // One clock edge of the model: accept when the previous result's done cycle is
    // at least two cycles back, result = plain integer division.
    task automatic model_edge(input int u);
        int  a, b, w;
        bit  s;
        if (u == 0) begin s = st8;  a = int'(dd8);  b = int'(dv8);  w = 8;  end
        else        begin s = st16; a = int'(dd16); b = int'(dv16); w = 16; end
        if (s && cyc >= m_done[u] + 2) begin
            m_acc[u] = cyc;
            m_nacc[u]++;
            if (b == 0) begin
                p_q[u] = (1 << w) - 1; p_r[u] = a; p_z[u] = 1;
                m_done[u] = cyc;
            end else begin
                p_q[u] = a / b; p_r[u] = a % b; p_z[u] = 0;
                m_done[u] = cyc + w;
            end
        end
        if (cyc == m_done[u]) begin
            m_q[u] = p_q[u]; m_r[u] = p_r[u]; m_z[u] = p_z[u];
        end
    endtask

    initial forever begin
        @(negedge rst_n);
        model_clear();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) model_clear();
        else for (int u = 0; u < 2; u++) model_edge(u);
    end

    initial forever begin
        @(negedge clk);
        chk("done8",  done8,  (cyc == m_done[0]));
        chk("busy8",  busy8,  (cyc >= m_acc[0] && cyc <= m_done[0]));
        chk("q8",     q8,     m_q[0]);
        chk("r8",     r8,     m_r[0]);
        chk("dz8",    dz8,    m_z[0]);
        chk("done16", done16, (cyc == m_done[1]));
        chk("busy16", busy16, (cyc >= m_acc[1] && cyc <= m_done[1]));
        chk("q16",    q16,    m_q[1]);
        chk("r16",    r16,    m_r[1]);
        chk("dz16",   dz16,   m_z[1]);
    end

    // Issue one request on the 8-bit unit and return at the negedge where done is seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(posedge clk); #2;
        st8 = 1'b1; dd8 = a; dv8 = b;
        @(posedge clk); #2;
        st8 = 1'b0; dd8 = 8'($urandom); dv8 = 8'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done8) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic pick(input int w, output int a, output int b);
        int mask, cat;
        mask = (1 << w) - 1;
        cat  = int'($urandom_range(0, 9));
        a    = int'($urandom) & mask;
        b    = int'($urandom) & mask;
        case (cat)
            0: b = 1;
            1: a = 0;
            2: b = a;
            3: b = 0;
            4: b = int'($urandom_range(1, 3));
            default: ;
        endcase
    endtask

    initial begin
        int lat, nd, gq, gr, a, b;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        repeat (20) begin
            @(negedge clk);
            chk("idle busy", busy8, 0);
            chk("idle done", done8, 0);
            chk("idle q", q8, 0);
            chk("idle r", r8, 0);
            chk("idle dz", dz8, 0);
        end

        run8(8'd100, 8'd7, lat);
        chk("100/7 latency", lat, 9);
        chk("100/7 q", q8, 14);
        chk("100/7 r", r8, 2);
        chk("100/7 dz", dz8, 0);
        chk("model 100/7 q", m_q[0], 14);

        run8(8'd255, 8'd1, lat);
        chk("255/1 latency", lat, 9);
        chk("255/1 q", q8, 255);
        chk("255/1 r", r8, 0);
        run8(8'd3, 8'd10, lat);
        chk("3/10 latency", lat, 9);
        chk("3/10 q", q8, 0);
        chk("3/10 r", r8, 3);

        run8(8'd5, 8'd0, lat);
        chk("5/0 latency", lat, 1);
        chk("5/0 q", q8, 255);
        chk("5/0 r", r8, 5);
        chk("5/0 dz", dz8, 1);
        chk("model 5/0 r", m_r[0], 5);
        run8(8'd9, 8'd3, lat);
        chk("9/3 q", q8, 3);
        chk("9/3 r", r8, 0);
        chk("9/3 dz", dz8, 0);

        // Second request and operand changes while running must be ignored
        @(posedge clk); #2;
        st8 = 1'b1; dd8 = 8'd200; dv8 = 8'd9;
        @(posedge clk); #2;
        st8 = 1'b0; dd8 = 8'd77; dv8 = 8'd3;
        repeat (3) @(posedge clk);
        #2 st8 = 1'b1; dd8 = 8'd50; dv8 = 8'd5;
        @(posedge clk); #2;
        st8 = 1'b0; dd8 = 8'd1; dv8 = 8'd0;
        nd = 0; gq = -1; gr = -1;
        repeat (20) begin
            @(negedge clk);
            if (done8) begin nd++; gq = int'(q8); gr = int'(r8); end
        end
        chk("midrun done count", nd, 1);
        chk("midrun q", gq, 22);
        chk("midrun r", gr, 2);

        // Reset in the middle of a run aborts it
        @(posedge clk); #2;
        st8 = 1'b1; dd8 = 8'd200; dv8 = 8'd9;
        @(posedge clk); #2;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy8, 0);
        chk("rst done", done8, 0);
        chk("rst q", q8, 0);
        chk("rst r", r8, 0);
        chk("rst dz", dz8, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("post-reset done count", nd, 0);
        run8(8'd17, 8'd4, lat);
        chk("17/4 latency", lat, 9);
        chk("17/4 q", q8, 4);
        chk("17/4 r", r8, 1);

        // Random sweep on both widths, start requests arriving in any state
        repeat (4000) begin
            @(posedge clk); #2;
            pick(8, a, b);
            st8 = ($urandom_range(0, 3) == 0); dd8 = 8'(a); dv8 = 8'(b);
            pick(16, a, b);
            st16 = ($urandom_range(0, 3) == 0); dd16 = 16'(a); dv16 = 16'(b);
        end
        @(posedge clk); #2;
        st8 = 1'b0; st16 = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("sweep8 ops>100", (m_nacc[0] > 100), 1);
        chk("sweep16 ops>100", (m_nacc[1] > 100), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
